// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush and EX busy hold. Optional statistics counters: HAZARD_STATS_EN.
module id_ex_hazard_reg #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [XLEN-1:0] id_rdata1,
    input  logic [XLEN-1:0] id_rdata2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,
    input  logic            id_branch,
    input  logic            id_alusrc,
    input  logic [1:0]      id_aluop,
    input  logic [3:0]      id_funct,
    input  logic            ex_flush,
    input  logic            ex_busy,
    output logic            ID_EX_valid,
    output logic [XLEN-1:0] ID_EX_pc,
    output logic [4:0]      ID_EX_Rs1,
    output logic [4:0]      ID_EX_Rs2,
    output logic [4:0]      ID_EX_Rd,
    output logic [XLEN-1:0] ID_EX_rdata1,
    output logic [XLEN-1:0] ID_EX_rdata2,
    output logic [XLEN-1:0] ID_EX_imm,
    output logic            ID_EX_RegW,
    output logic            ID_EX_MemRead,
    output logic            ID_EX_MemWrite,
    output logic            ID_EX_MemToReg,
    output logic            ID_EX_Branch,
    output logic            ID_EX_ALUSrc,
    output logic [1:0]      ID_EX_ALUOp,
    output logic [3:0]      ID_EX_funct,
    output logic            stall_pc,
    output logic            stall_ifid,
    output logic [31:0]     bubble_count,
    output logic [31:0]     hold_count,
    output logic [31:0]     flush_count
);

    localparam int unsigned RW = 5;
    localparam int unsigned OW = 2;
    localparam int unsigned FW = 4;
    localparam int unsigned CW = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic            regw;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            branch;
        logic            alusrc;
        logic [OW-1:0]   aluop;
        logic [FW-1:0]   funct;
    } idex_t;

    idex_t ex_q;
    idex_t ex_d;
    idex_t id_entry_c;

    logic load_use_c;
    logic stall_c;
    logic hold_c;
    logic bubble_c;

    // Entry as decoded in ID; an empty ID slot becomes an all-zero bubble.
    always_comb begin
        id_entry_c          = '0;
        if (id_valid) begin
            id_entry_c.valid    = 1'b1;
            id_entry_c.pc       = id_pc;
            id_entry_c.rs1      = id_rs1;
            id_entry_c.rs2      = id_rs2;
            id_entry_c.rd       = id_rd;
            id_entry_c.rdata1   = id_rdata1;
            id_entry_c.rdata2   = id_rdata2;
            id_entry_c.imm      = id_imm;
            id_entry_c.regw     = id_regwrite;
            id_entry_c.memread  = id_memread;
            id_entry_c.memwrite = id_memwrite;
            id_entry_c.memtoreg = id_memtoreg;
            id_entry_c.branch   = id_branch;
            id_entry_c.alusrc   = id_alusrc;
            id_entry_c.aluop    = id_aluop;
            id_entry_c.funct    = id_funct;
        end
    end

    // Load in EX whose destination is read by the instruction in ID; x0 never matches.
    assign load_use_c = ex_q.valid & ex_q.memread & (ex_q.rd != RW'(0)) & id_valid &
                        ((id_uses_rs1 & (id_rs1 == ex_q.rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_q.rd)));

    assign hold_c   = ~ex_flush & ex_busy;
    assign bubble_c = ~ex_flush & ~ex_busy & load_use_c;
    assign stall_c  = ~rst & ~ex_flush & (ex_busy | load_use_c);

    assign stall_pc   = stall_c;
    assign stall_ifid = stall_c;

    // Next entry: flush and load-use insert a bubble, busy holds, else take ID.
    always_comb begin
        ex_d = id_entry_c;
        if (ex_flush) begin
            ex_d = '0;
        end else if (ex_busy) begin
            ex_d = ex_q;
        end else if (load_use_c) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ID_EX_valid    = ex_q.valid;
    assign ID_EX_pc       = ex_q.pc;
    assign ID_EX_Rs1      = ex_q.rs1;
    assign ID_EX_Rs2      = ex_q.rs2;
    assign ID_EX_Rd       = ex_q.rd;
    assign ID_EX_rdata1   = ex_q.rdata1;
    assign ID_EX_rdata2   = ex_q.rdata2;
    assign ID_EX_imm      = ex_q.imm;
    assign ID_EX_RegW     = ex_q.regw;
    assign ID_EX_MemRead  = ex_q.memread;
    assign ID_EX_MemWrite = ex_q.memwrite;
    assign ID_EX_MemToReg = ex_q.memtoreg;
    assign ID_EX_Branch   = ex_q.branch;
    assign ID_EX_ALUSrc   = ex_q.alusrc;
    assign ID_EX_ALUOp    = ex_q.aluop;
    assign ID_EX_funct    = ex_q.funct;

`ifdef HAZARD_STATS_EN
    logic [CW-1:0] bubble_cnt_q;
    logic [CW-1:0] hold_cnt_q;
    logic [CW-1:0] flush_cnt_q;
    logic [CW-1:0] bubble_cnt_d;
    logic [CW-1:0] hold_cnt_d;
    logic [CW-1:0] flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble_c && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CW'(1);
        end
        if (hold_c && (hold_cnt_q != '1)) begin
            hold_cnt_d = hold_cnt_q + CW'(1);
        end
        if (ex_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_count = bubble_cnt_q;
    assign hold_count   = hold_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign bubble_count = CW'(0);
    assign hold_count   = CW'(0);
    assign flush_count  = CW'(0);
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Randomized self-checking bench for id_ex_hazard_reg against a cycle-level
// reference model of the pipeline-register rules.
module tb_id_ex_hazard_reg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic            regw;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            branch;
        logic            alusrc;
        logic [1:0]      aluop;
        logic [3:0]      funct;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_uses_rs1, id_uses_rs2;
    logic [XLEN-1:0] id_rdata1, id_rdata2, id_imm;
    logic            id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch, id_alusrc;
    logic [1:0]      id_aluop;
    logic [3:0]      id_funct;
    logic            ex_flush, ex_busy;
    logic            ID_EX_valid;
    logic [XLEN-1:0] ID_EX_pc;
    logic [4:0]      ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
    logic [XLEN-1:0] ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm;
    logic            ID_EX_RegW, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg;
    logic            ID_EX_Branch, ID_EX_ALUSrc;
    logic [1:0]      ID_EX_ALUOp;
    logic [3:0]      ID_EX_funct;
    logic            stall_pc, stall_ifid;
    logic [31:0]     bubble_count, hold_count, flush_count;

    int checks   = 0;
    int failures = 0;

    entry_t      m = '0;
    logic [31:0] mb = 0, mh = 0, mf = 0;

    id_ex_hazard_reg #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_branch(id_branch), .id_alusrc(id_alusrc),
        .id_aluop(id_aluop), .id_funct(id_funct),
        .ex_flush(ex_flush), .ex_busy(ex_busy),
        .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc),
        .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2), .ID_EX_Rd(ID_EX_Rd),
        .ID_EX_rdata1(ID_EX_rdata1), .ID_EX_rdata2(ID_EX_rdata2), .ID_EX_imm(ID_EX_imm),
        .ID_EX_RegW(ID_EX_RegW), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUSrc(ID_EX_ALUSrc),
        .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_funct(ID_EX_funct),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .bubble_count(bubble_count), .hold_count(hold_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic entry_t dut_entry();
        return {ID_EX_valid, ID_EX_pc, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_rdata1,
                ID_EX_rdata2, ID_EX_imm, ID_EX_RegW, ID_EX_MemRead, ID_EX_MemWrite,
                ID_EX_MemToReg, ID_EX_Branch, ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_funct};
    endfunction

    function automatic entry_t id_entry();
        return {1'b1, id_pc, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2, id_imm,
                id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch,
                id_alusrc, id_aluop, id_funct};
    endfunction

    // Does the ID instruction read the register a valid load in EX is about to write?
    function automatic logic model_load_use();
        logic reads_it;
        reads_it = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
        return m.valid && m.memread && (m.rd != 0) && id_valid && reads_it;
    endfunction

    function automatic logic model_stall();
        if (rst || ex_flush) return 1'b0;
        return ex_busy || model_load_use();
    endfunction

    function automatic logic [95:0] model_counts();
`ifdef HAZARD_STATS_EN
        return {mb, mh, mf};
`else
        return 96'd0;
`endif
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    // Advance one clock edge, updating the reference model alongside the DUT.
    task automatic tick();
        entry_t nxt;
        if (rst) begin
            nxt = '0; mb = 0; mh = 0; mf = 0;
        end else if (ex_flush) begin
            nxt = '0; mf = sat_inc(mf);
        end else if (ex_busy) begin
            nxt = m; mh = sat_inc(mh);
        end else if (model_load_use()) begin
            nxt = '0; mb = sat_inc(mb);
        end else begin
            nxt = id_valid ? id_entry() : entry_t'(0);
        end
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic u1, input logic u2,
                             input logic rw, input logic mr, input logic mw,
                             input logic [1:0] op, input logic [3:0] fn);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mr;
        id_branch = 1'b0; id_alusrc = mr | mw; id_aluop = op; id_funct = fn;
        id_pc = $urandom; id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
    endtask

    task automatic randomize_id();
        id_valid = ($urandom_range(0, 3) != 0);
        id_pc = $urandom; id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
        id_regwrite = 1'($urandom); id_memread = 1'($urandom); id_memwrite = 1'($urandom);
        id_memtoreg = 1'($urandom); id_branch = 1'($urandom); id_alusrc = 1'($urandom);
        id_aluop = 2'($urandom); id_funct = 4'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            randomize_id();
            ex_flush = 1'($urandom); ex_busy = 1'($urandom);
            #1;
            checks++;
            if (stall_pc !== 1'b0 || stall_ifid !== 1'b0) begin
                failures++;
                $display("FAIL reset_stall: got pc=%b ifid=%b, want 0", stall_pc, stall_ifid);
            end
            tick();
            checks++;
            if (dut_entry() !== entry_t'(0)) begin
                failures++;
                $display("FAIL reset_fields: got %h, want 0", dut_entry());
            end
            checks++;
            if ({bubble_count, hold_count, flush_count} !== 96'd0) begin
                failures++;
                $display("FAIL reset_counters: got %h/%h/%h, want 0", bubble_count, hold_count, flush_count);
            end
        end
        rst = 1'b0; ex_flush = 1'b0; ex_busy = 1'b0;
    endtask

    task automatic test_load_use();
        set_instr(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 2'd0, 4'd2);   // lw x5,0(x2)
        tick();
        set_instr(1, 5'd5, 5'd7, 5'd6, 1, 1, 1, 0, 0, 2'd2, 4'd0);   // add x6,x5,x7
        #1;
        checks++;
        if (stall_pc !== 1'b1 || stall_ifid !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall: got pc=%b ifid=%b, want 1", stall_pc, stall_ifid);
        end
        tick();
        checks++;
        if (ID_EX_valid !== 1'b0 || ID_EX_RegW !== 1'b0 || dut_entry() !== m) begin
            failures++;
            $display("FAIL load_use_bubble: got %h, want %h", dut_entry(), m);
        end
        checks++;
        if (stall_pc !== 1'b0 || stall_ifid !== 1'b0) begin
            failures++;
            $display("FAIL load_use_release: got pc=%b ifid=%b, want 0", stall_pc, stall_ifid);
        end
        tick();
        checks++;
        if (ID_EX_valid !== 1'b1 || ID_EX_Rs1 !== 5'd5 || dut_entry() !== m) begin
            failures++;
            $display("FAIL load_use_reload: got %h, want %h", dut_entry(), m);
        end
    endtask

    task automatic test_false_hazard();
        set_instr(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 2'd0, 4'd2);   // lw x5
        tick();
        set_instr(1, 5'd5, 5'd5, 5'd5, 0, 0, 1, 0, 0, 2'd0, 4'd0);   // lui x5 (no reads)
        #1;
        checks++;
        if (stall_pc !== 1'b0 || stall_ifid !== 1'b0) begin
            failures++;
            $display("FAIL false_hazard_lui: got pc=%b ifid=%b, want 0", stall_pc, stall_ifid);
        end
        set_instr(1, 5'd2, 5'd0, 5'd0, 1, 0, 1, 1, 0, 2'd0, 4'd2);   // lw x0
        tick();
        set_instr(1, 5'd0, 5'd0, 5'd9, 1, 1, 1, 0, 0, 2'd2, 4'd0);   // reads x0
        #1;
        checks++;
        if (stall_pc !== 1'b0 || stall_ifid !== 1'b0) begin
            failures++;
            $display("FAIL false_hazard_x0: got pc=%b ifid=%b, want 0", stall_pc, stall_ifid);
        end
        tick();
        checks++;
        if (dut_entry() !== m) begin
            failures++;
            $display("FAIL false_hazard_load: got %h, want %h", dut_entry(), m);
        end
    endtask

    task automatic test_busy_hold();
        entry_t      held;
        logic [31:0] h0;
        set_instr(1, 5'd3, 5'd4, 5'd8, 1, 1, 1, 0, 0, 2'd2, 4'b1000); // mul x8,x3,x4
        tick();
        held = m;
        h0   = hold_count;
        for (int c = 0; c < 3; c++) begin
            randomize_id();
            ex_busy = 1'b1;
            #1;
            checks++;
            if (stall_pc !== 1'b1 || stall_ifid !== 1'b1) begin
                failures++;
                $display("FAIL busy_stall[%0d]: got pc=%b ifid=%b, want 1", c, stall_pc, stall_ifid);
            end
            tick();
            checks++;
            if (dut_entry() !== held) begin
                failures++;
                $display("FAIL busy_hold[%0d]: got %h, want %h", c, dut_entry(), held);
            end
        end
        ex_busy = 1'b0;
        checks++;
`ifdef HAZARD_STATS_EN
        if (hold_count !== h0 + 32'd3) begin
            failures++;
            $display("FAIL busy_hold_count: got %0d, want %0d", hold_count, h0 + 32'd3);
        end
`else
        if (hold_count !== 32'd0) begin
            failures++;
            $display("FAIL busy_hold_count: got %0d, want 0", hold_count);
        end
`endif
    endtask

    task automatic test_flush_priority();
        logic [31:0] b0, f0;
        set_instr(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 2'd0, 4'd2);   // lw x5
        tick();
        b0 = mb; f0 = mf;
        set_instr(1, 5'd1, 5'd5, 5'd6, 1, 1, 1, 0, 0, 2'd2, 4'd0);   // add x6,x1,x5
        ex_flush = 1'b1;
        #1;
        checks++;
        if (stall_pc !== 1'b0 || stall_ifid !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall: got pc=%b ifid=%b, want 0", stall_pc, stall_ifid);
        end
        tick();
        ex_flush = 1'b0;
        checks++;
        if (dut_entry() !== entry_t'(0)) begin
            failures++;
            $display("FAIL flush_bubble: got %h, want 0", dut_entry());
        end
        checks++;
`ifdef HAZARD_STATS_EN
        if (flush_count !== f0 + 32'd1 || bubble_count !== b0) begin
            failures++;
            $display("FAIL flush_counts: got f=%0d b=%0d, want f=%0d b=%0d", flush_count, bubble_count, f0 + 32'd1, b0);
        end
`else
        if (flush_count !== 32'd0 || bubble_count !== 32'd0) begin
            failures++;
            $display("FAIL flush_counts: got f=%0d b=%0d, want 0", flush_count, bubble_count);
        end
`endif
    endtask

    task automatic test_busy_load_use();
        int stalls = 0;
        set_instr(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 2'd0, 4'd2);   // lw x5
        tick();
        set_instr(1, 5'd5, 5'd0, 5'd6, 1, 0, 1, 0, 0, 2'd2, 4'd0);   // addi x6,x5
        for (int c = 0; c < 6; c++) begin
            ex_busy = (c < 2);
            #1;
            if (stall_pc === 1'b1) stalls++;
            checks++;
            if (stall_pc !== model_stall() || stall_ifid !== model_stall()) begin
                failures++;
                $display("FAIL busy_lu_stall[%0d]: got pc=%b ifid=%b, want %b", c, stall_pc, stall_ifid, model_stall());
            end
            tick();
            checks++;
            if (dut_entry() !== m) begin
                failures++;
                $display("FAIL busy_lu_entry[%0d]: got %h, want %h", c, dut_entry(), m);
            end
        end
        checks++;
        if (stalls != 3 || ID_EX_Rs1 !== 5'd5 || ID_EX_valid !== 1'b1) begin
            failures++;
            $display("FAIL busy_lu_total: got stalls=%0d rs1=%0d, want stalls=3 rs1=5", stalls, ID_EX_Rs1);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_instr(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 2'd0, 4'd2);   // lw x5
        tick();
        set_instr(1, 5'd5, 5'd0, 5'd6, 1, 0, 1, 0, 0, 2'd2, 4'd0);
        rst = 1'b1;
        #1;
        checks++;
        if (stall_pc !== 1'b0 || stall_ifid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_stall: got pc=%b ifid=%b, want 0", stall_pc, stall_ifid);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (dut_entry() !== entry_t'(0)) begin
            failures++;
            $display("FAIL rst_mid_clear: got %h, want 0", dut_entry());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            randomize_id();
            rst      = ($urandom_range(0, 59) == 0);
            ex_flush = ($urandom_range(0, 9) == 0);
            ex_busy  = ($urandom_range(0, 4) == 0);
            #1;
            checks++;
            if (stall_pc !== model_stall() || stall_ifid !== model_stall()) begin
                failures++;
                $display("FAIL rand_stall[%0d]: got pc=%b ifid=%b, want %b", c, stall_pc, stall_ifid, model_stall());
            end
            tick();
            checks++;
            if (dut_entry() !== m) begin
                failures++;
                $display("FAIL rand_entry[%0d]: got %h, want %h", c, dut_entry(), m);
            end
            checks++;
            if ({bubble_count, hold_count, flush_count} !== model_counts()) begin
                failures++;
                $display("FAIL rand_counts[%0d]: got %h, want %h", c, {bubble_count, hold_count, flush_count}, model_counts());
            end
        end
        rst = 1'b0; ex_flush = 1'b0; ex_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ex_flush = 1'b0; ex_busy = 1'b0;
        set_instr(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
        #1;
        test_reset();
        test_load_use();
        test_false_hazard();
        test_busy_hold();
        test_flush_priority();
        test_busy_load_use();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core, with integrated load-use hazard detection and bubble insertion.
- Captures decoded operands and control from ID and presents the ID_EX_* fields consumed by EX, including Rs1/Rs2 for operand forwarding.
- Drives stall requests to the PC and IF/ID registers.
- Honours a branch flush and a multi-cycle EX busy hold.

Parameters:
- XLEN, 32, datapath width for PC, register operands and immediate.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rdata1, id_rdata2  in  XLEN each  register file read data
- id_imm  in  XLEN  immediate
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch, id_alusrc  in  1 each  control
- id_aluop  in  2  ALU op class
- id_funct  in  4  {funct7[5], funct3}
- ex_flush  in  1  taken branch/jump resolved; squash ID instruction
- ex_busy  in  1  multi-cycle EX op not done; hold EX
- ID_EX_valid, ID_EX_pc, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm, ID_EX_RegW, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_Branch, ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_funct  out  widths as inputs  registered fields
- stall_pc  out  1  PC must hold
- stall_ifid  out  1  IF/ID must hold
- bubble_count, hold_count, flush_count  out  32 each  statistics (see Optional Feature)

Behaviour:
- All ID_EX_* outputs are registers.
- On rst, every ID_EX_* output is 0 and all counters are 0.
- stall_pc and stall_ifid are combinational and identical.
- load_use = ID_EX_valid & ID_EX_MemRead & (ID_EX_Rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ID_EX_Rd) | (id_uses_rs2 & id_rs2 == ID_EX_Rd)).
- Per-cycle update, priority highest first:
  1. rst: all outputs cleared.
  2. ex_flush: load bubble (valid and all control = 0; Rs1/Rs2/Rd = 0; data fields don't-care, driven 0). stall = 0.
  3. ex_busy: hold all ID_EX_* unchanged. stall = 1.
  4. load_use: load bubble. stall = 1.
  5. Otherwise: load all fields from id_*. stall = 0.
- When id_valid = 0 and no other case applies, the loaded entry is a bubble (valid = 0, control = 0).
- Bubbles always carry RegW = 0, MemRead = 0 and Rd = 0, so downstream forwarding and hazard logic never match on them.
- A load-use stall lasts exactly one cycle: the bubble clears ID_EX_MemRead, so load_use drops next cycle and the held ID instruction is loaded.
- ex_busy asserted while load_use is true: hold takes priority; the bubble is inserted on the first cycle ex_busy = 0 if load_use is still true.
- ex_flush together with ex_busy: flush wins and the busy op is abandoned; the EX unit is responsible for cancelling it.
- Reset mid-stall: stall deasserts in the same cycle and registers clear next edge.
- x0 writes never create a hazard.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: three 32-bit saturating counters, cleared on rst.
  - bubble_count increments on each load-use bubble insertion.
  - hold_count increments on each ex_busy hold cycle.
  - flush_count increments on each cycle ex_flush = 1.
  - Counters stop at 32'hFFFF_FFFF.
- Not defined: ports remain and are tied to 0; no counter flops are synthesised.

Test Plan:
- Reset: rst = 1 for 2 cycles with arbitrary id_* inputs -> all ID_EX_* = 0, stall_pc = stall_ifid = 0.
- Load-use: `lw x5` in EX (MemRead = 1, Rd = 5), ID `add x6,x5,x7` (uses_rs1, rs1 = 5) -> stall = 1 for one cycle, ID_EX_valid = 0 and RegW = 0 next cycle, then the add loads with ID_EX_Rs1 = 5.
- False hazard: `lw x5` in EX, ID `lui x5` (uses_rs1 = uses_rs2 = 0), then `lw x0` in EX with ID rs1 = 0 -> no stall in either case.
- Busy hold: ex_busy = 1 for 3 cycles with ID_EX holding a `mul` -> ID_EX fields unchanged, stall = 1 for 3 cycles, hold_count = 3 with HAZARD_STATS_EN.
- Flush priority: load_use true and ex_flush = 1 in the same cycle -> stall = 0, bubble loaded, flush_count = 1, bubble_count = 0.
- Busy plus load-use: ex_busy = 1 for 2 cycles while load_use is true -> hold for 2 cycles, then bubble, then ID instruction loads; total stall = 3 cycles.
